// File: rtl/key_decoder_pkg.sv
// Shared key codes, FSM state encoding and one-hot event bit positions
// for the cap-touch cursor key decoder.
package key_decoder_pkg;

    localparam logic [2:0] KEY_NONE  = 3'd0;
    localparam logic [2:0] KEY_UP    = 3'd1;
    localparam logic [2:0] KEY_DOWN  = 3'd2;
    localparam logic [2:0] KEY_LEFT  = 3'd3;
    localparam logic [2:0] KEY_RIGHT = 3'd4;

    localparam int unsigned EV_UP    = 0;
    localparam int unsigned EV_DOWN  = 1;
    localparam int unsigned EV_LEFT  = 2;
    localparam int unsigned EV_RIGHT = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_REPEAT   = 2'd3
    } state_t;

    // Anything outside the four direction codes reads as "no key".
    function automatic logic [2:0] filter_code(input logic [2:0] k);
        case (k)
            KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT: filter_code = k;
            default:                               filter_code = KEY_NONE;
        endcase
    endfunction

    function automatic logic [3:0] event_onehot(input logic [2:0] k);
        event_onehot = '0;
        case (k)
            KEY_UP:    event_onehot[EV_UP]    = 1'b1;
            KEY_DOWN:  event_onehot[EV_DOWN]  = 1'b1;
            KEY_LEFT:  event_onehot[EV_LEFT]  = 1'b1;
            KEY_RIGHT: event_onehot[EV_RIGHT] = 1'b1;
            default:   event_onehot = '0;
        endcase
    endfunction

endpackage

// File: rtl/key_decoder_wrap_counter.sv
// Modulo-N up/down counter using compare-and-wrap (no modulo operator),
// used for one cursor axis.
module wrap_counter #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end else if (dec) begin
            count_d = (count_q == '0) ? LAST : count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/key_decoder.sv
// Debounces cap-touch direction keys, generates one-hot key events with
// auto-repeat, and maintains a wrapping cursor position.
module key_decoder
    import key_decoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_RATE     = 100000,
    parameter int COLS            = 64,
    parameter int ROWS            = 48,
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    keys,
    output logic [3:0]    key_event,
    output logic          key_held,
    output logic [XW-1:0] cursor_x,
    output logic [YW-1:0] cursor_y
);

    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] DEB_LOAD = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LOAD = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RPT_LOAD = CW'(REPEAT_RATE - 1);

    state_t        state_q, state_d;
    logic [2:0]    code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    event_q, event_d;
    logic          held_q, held_d;
    logic [2:0]    key_in;

    always_comb begin
        key_in  = filter_code(keys);
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        event_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (key_in != KEY_NONE) begin
                    code_d  = key_in;
                    cnt_d   = DEB_LOAD;
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (key_in == KEY_NONE) begin
                    code_d  = KEY_NONE;
                    state_d = ST_IDLE;
                end else if (key_in != code_q) begin
                    code_d = key_in;
                    cnt_d  = DEB_LOAD;
                end else if (cnt_q == '0) begin
                    event_d = event_onehot(code_q);
                    cnt_d   = DLY_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLD, ST_REPEAT: begin
                // A changed key is never accepted here; IDLE re-debounces it.
                if (keys != code_q) begin
                    code_d  = KEY_NONE;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    event_d = event_onehot(code_q);
                    cnt_d   = RPT_LOAD;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                code_d  = KEY_NONE;
                state_d = ST_IDLE;
            end
        endcase

        held_d = (state_d == ST_HOLD) || (state_d == ST_REPEAT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            code_q  <= KEY_NONE;
            cnt_q   <= '0;
            event_q <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            event_q <= event_d;
            held_q  <= held_d;
        end
    end

    assign key_event = event_q;
    assign key_held  = held_q;

    // Cursor axes step on the same edge that registers the event.
    wrap_counter #(.N(COLS)) u_x (
        .clk   (clk),
        .reset (reset),
        .inc   (event_d[EV_RIGHT]),
        .dec   (event_d[EV_LEFT]),
        .count (cursor_x)
    );

    wrap_counter #(.N(ROWS)) u_y (
        .clk   (clk),
        .reset (reset),
        .inc   (event_d[EV_DOWN]),
        .dec   (event_d[EV_UP]),
        .count (cursor_y)
    );

endmodule

// File: doc/key_decoder.md
KEY_DECODER -- requirements
Module: key_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000, meaning the number of consecutive clocks a code must be stable before it is accepted (min 1).
REQ-002 SHALL have parameter REPEAT_DELAY, default 500000, meaning the number of clocks from the first event to the first auto-repeat event (min 1).
REQ-003 SHALL have parameter REPEAT_RATE, default 100000, meaning the number of clocks between later auto-repeat events (min 1).
REQ-004 SHALL have parameters COLS, default 64, and ROWS, default 48, giving the cursor grid size (each min 2); XW = $clog2(COLS), YW = $clog2(ROWS).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port keys, input, 3, a key code from the cap-touch block, synchronous to clk; codes are the KEY_* values of key_codes.vh, and 0 means no key.
REQ-008 SHALL have port key_event, output, 4, a registered one-hot pulse: bit0 up, bit1 down, bit2 left, bit3 right.
REQ-009 SHALL have port key_held, output, 1, registered, high while an accepted key is still pressed.
REQ-010 SHALL have ports cursor_x, output, XW, and cursor_y, output, YW, the registered cursor position.

Function
REQ-011 SHALL treat any keys value other than the four KEY_* codes as 0.
REQ-012 SHALL implement an FSM with states IDLE, DEBOUNCE, HOLD and REPEAT, a latched code register, and one down-counter sized to the largest parameter.
REQ-013 In IDLE, a valid nonzero code SHALL latch the code, load the counter with DEBOUNCE_CYCLES-1 and go to DEBOUNCE; otherwise the FSM stays in IDLE.
REQ-014 In DEBOUNCE, if keys is 0, the FSM SHALL go to IDLE.
REQ-015 In DEBOUNCE, if keys is a different valid code, the FSM SHALL re-latch the code, reload the counter and stay in DEBOUNCE.
REQ-016 In DEBOUNCE, if the counter is 0 and keys still equals the latched code, the FSM SHALL pulse key_event for one cycle, load the counter with REPEAT_DELAY-1 and go to HOLD.
REQ-017 In DEBOUNCE, in all other cases, the counter SHALL decrement.
REQ-018 Timing SHALL be: with keys stable from edge N, key_event is high in the cycle after edge N+DEBOUNCE_CYCLES.
REQ-019 In HOLD and REPEAT, any keys value not equal to the latched code SHALL send the FSM to IDLE on that edge with no event; a new code is re-debounced from IDLE.
REQ-020 In HOLD, when the counter is 0, the FSM SHALL pulse key_event, load the counter with REPEAT_RATE-1 and go to REPEAT.
REQ-021 In REPEAT, when the counter is 0, the FSM SHALL pulse key_event and reload the counter with REPEAT_RATE-1.
REQ-022 key_held SHALL be 1 exactly when the state is HOLD or REPEAT.
REQ-023 key_event SHALL never have more than one bit set, and SHALL be 0 in every cycle without an event.
REQ-024 The cursor SHALL update on the same edge that registers the event: up decrements cursor_y, down increments cursor_y, left decrements cursor_x, right increments cursor_x.
REQ-025 The cursor SHALL wrap around: 0-1 becomes ROWS-1 (or COLS-1), and ROWS-1+1 (or COLS-1+1) becomes 0; all arithmetic is compare-and-wrap, with no modulo on non-power-of-2 sizes.

Reset
REQ-026 Asserting reset SHALL immediately force: state IDLE, latched code 0, counter 0, key_event 0, key_held 0, cursor_x 0, cursor_y 0.
REQ-027 Reset asserted mid-DEBOUNCE, mid-HOLD or mid-REPEAT SHALL abort with no event; after deassertion, a key that is still held SHALL be re-debounced from IDLE.

Structure
REQ-028 The KEY_* codes SHALL come from the shared key_codes.vh; state encodings and the one-hot event bit indices SHALL be added to that shared header.
REQ-029 SHALL contain one sub-module, wrap_counter (parameter N; inputs inc and dec; output count in [0,N-1]), instantiated once for x and once for y.

Verification (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, COLS=8, ROWS=6)
REQ-030 Drive KEY_RIGHT from edge 0 for 5 cycles, then 0 -> a single key_event=4'b1000 in cycle 5, cursor_x=1, key_held high for 1 cycle, no further events.
REQ-031 Drive KEY_DOWN for 3 cycles, 0 for 1 cycle, then KEY_DOWN for 3 cycles -> no event, cursor_y stays 0; then drive a 1-cycle invalid code 3'b111 -> no event.
REQ-032 Hold KEY_UP for 30 cycles -> events in cycles 5, 15, 18, 21, 24, 27 (6 events); cursor_y sequence 5,4,3,2,1,0 (wraps on the first event).
REQ-033 Press KEY_LEFT until the event, then switch to KEY_RIGHT without release -> return to IDLE, then a KEY_RIGHT event 5 cycles later; cursor_x goes 7 then back to 0.
REQ-034 Assert reset asynchronously (between edges) during REPEAT with cursor (3,2) -> all outputs 0 immediately; after release with the key still held, the next event occurs 5 cycles later.
